// File: rtl/lsq_mem_issue.sv
// lsq_mem_issue: in-order load/store queue issuing one memory op at a time to the cache,
// retiring loads with a one-cycle result pulse (hit data, or a miss marker after a fixed penalty).
module lsq_mem_issue #(
  parameter int DEPTH        = 8,
  parameter int MISS_PENALTY = 10,
  parameter int TAG_W        = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_store,
  input  logic             in_size,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [31:0]      in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      PC_out,
  output logic [31:0]      address_out,
  output logic [31:0]      data_sw,
  output logic             memRead,
  output logic             memWrite,
  output logic             storeSize,
  output logic             fromLSQ,
  input  logic [31:0]      lw_data,
  input  logic             cacheMiss,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic             res_miss
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MISS_PENALTY + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, MISS_WAIT} state_t;
  typedef struct packed {
    logic             is_store;
    logic             size;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } entry_t;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d, res_miss_q, res_miss_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             push, pop, is_req;
  assign head        = mem_q[rd_ptr_q];
  assign is_req      = state_q == REQ;
  assign in_ready    = (count_q < (AW+1)'(DEPTH)) && !flush;
  assign push        = in_valid && in_ready;
  assign memRead     = is_req && !head.is_store;
  assign memWrite    = is_req && head.is_store;
  assign storeSize   = is_req && head.size;
  assign fromLSQ     = !is_req;
  assign address_out = is_req ? head.addr : '0;
  assign data_sw     = is_req ? head.data : '0;
  assign PC_out      = is_req ? head.pc : '0;
  assign res_valid   = res_valid_q;
  assign res_tag     = res_tag_q;
  assign res_data    = res_data_q;
  assign res_miss    = res_miss_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    res_valid_d = 1'b0;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    res_miss_d  = res_miss_q;
    case (state_q)
      IDLE: state_d = (count_q != '0) ? REQ : IDLE;
      REQ:  state_d = RESP;
      RESP: begin
        if (head.is_store || !cacheMiss) begin
          pop         = 1'b1;
          res_valid_d = !head.is_store;
          res_tag_d   = head.is_store ? res_tag_q : head.tag;
          res_data_d  = head.is_store ? res_data_q : lw_data;
          res_miss_d  = head.is_store ? res_miss_q : 1'b0;
        end else begin
          cnt_d   = CW'(MISS_PENALTY);
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          pop         = 1'b1;
          res_valid_d = 1'b1;
          res_tag_d   = head.tag;
          res_data_d  = '0;
          res_miss_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (pop) state_d = (count_d != '0) ? REQ : IDLE;
    // Flush discards everything, including a response arriving this cycle.
    if (flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      count_d     = '0;
      res_valid_d = 1'b0;
      res_tag_d   = res_tag_q;
      res_data_d  = res_data_q;
      res_miss_d  = res_miss_q;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
      res_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
      res_miss_q  <= res_miss_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_is_store, in_size, in_addr, in_data, in_pc, in_tag};
  end
endmodule

// File: tb/tb_lsq_mem_issue.sv
// tb_lsq_mem_issue: directed and random stimulus checked against a queue-level reference model
// that predicts cache requests, result pulses and in_ready from the ops accepted so far.
module tb_lsq_mem_issue;
  localparam int DEPTH = 8;
  localparam int P     = 10;
  localparam int TW    = 6;
  logic          clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic          in_is_store = 1'b0, in_size = 1'b0, cacheMiss = 1'b0;
  logic [31:0]   in_addr = '0, in_data = '0, in_pc = '0, lw_data = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, memRead, memWrite, storeSize, fromLSQ, res_valid, res_miss;
  logic [31:0]   PC_out, address_out, data_sw, res_data;
  logic [TW-1:0] res_tag;
  always #5 clk = ~clk;
  lsq_mem_issue #(.DEPTH(DEPTH), .MISS_PENALTY(P), .TAG_W(TW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_store(in_is_store), .in_size(in_size), .in_addr(in_addr), .in_data(in_data),
    .in_pc(in_pc), .in_tag(in_tag), .PC_out(PC_out), .address_out(address_out),
    .data_sw(data_sw), .memRead(memRead), .memWrite(memWrite), .storeSize(storeSize),
    .fromLSQ(fromLSQ), .lw_data(lw_data), .cacheMiss(cacheMiss), .res_valid(res_valid),
    .res_tag(res_tag), .res_data(res_data), .res_miss(res_miss)
  );
  typedef struct packed {
    logic          st;
    logic          sz;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [31:0]   pc;
    logic [TW-1:0] tag;
  } op_t;
  op_t           mq[$];
  op_t           head;
  int            reqs[$];
  int            compared = 0, mismatched = 0;
  int            n = 0, pop_n = 0, req_n = 0, res_n = 0, miss_pct = 0;
  bit            busy = 0, armed = 0, cur_req = 0, pushed = 0, res_now = 0, rand_data = 1;
  logic [31:0]   hit_data = '0, exp_data = '0, last_data = '0;
  logic          exp_miss = 1'b0, last_miss = 1'b0;
  logic [TW-1:0] last_tag = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    busy = 0; armed = 0; cur_req = 0;
    last_tag = '0; last_data = '0; last_miss = 1'b0;
  endtask
  // One clock: predict the effect of the edge from the accepted ops, then check every output.
  task automatic step();
    bit  v, f, rdy, miss;
    op_t o;
    v   = in_valid;
    f   = flush;
    o   = {in_is_store, in_size, in_addr, in_data, in_pc, in_tag};
    rdy = (mq.size() < DEPTH) && !f;
    @(posedge clk);
    #1;
    n++;
    pushed  = v && rdy;
    cur_req = 0;
    res_now = 0;
    if (f) begin
      mq.delete();
      busy = 0; armed = 0;
    end else begin
      if (pushed) mq.push_back(o);
      if (busy && n == pop_n) begin
        void'(mq.pop_front());
        busy = 0;
        if (!head.st) begin
          res_now = 1; res_n = n;
          last_tag = head.tag; last_data = exp_data; last_miss = exp_miss;
        end
        cur_req = mq.size() > 0;
      end else if (!busy && armed) cur_req = 1;
      armed = !busy && !cur_req && mq.size() > 0;
    end
    if (cur_req) begin
      busy  = 1;
      head  = mq[0];
      req_n = n;
      reqs.push_back(n);
      miss      = !head.st && (int'($urandom_range(99)) < miss_pct);
      cacheMiss = head.st ? 1'($urandom_range(1)) : miss;
      lw_data   = rand_data ? $urandom : hit_data;
      exp_miss  = miss;
      exp_data  = miss ? 32'h0 : lw_data;
      pop_n     = n + 2 + (miss ? P : 0);
    end
    chk("memRead", 32'(memRead), 32'(cur_req && !head.st));
    chk("memWrite", 32'(memWrite), 32'(cur_req && head.st));
    chk("storeSize", 32'(storeSize), 32'(cur_req && head.sz));
    chk("fromLSQ", 32'(fromLSQ), 32'(!cur_req));
    chk("address_out", address_out, cur_req ? head.addr : 32'h0);
    chk("data_sw", data_sw, cur_req ? head.data : 32'h0);
    chk("PC_out", PC_out, cur_req ? head.pc : 32'h0);
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH && !flush));
    chk("res_valid", 32'(res_valid), 32'(res_now));
    chk("res_tag", 32'(res_tag), 32'(last_tag));
    chk("res_data", res_data, last_data);
    chk("res_miss", 32'(res_miss), 32'(last_miss));
  endtask
  task automatic set_op(input bit st, input bit sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [TW-1:0] t);
    in_valid = 1'b1; in_is_store = st; in_size = sz;
    in_addr = a; in_data = d; in_pc = $urandom; in_tag = t;
  endtask
  task automatic rand_op();
    set_op(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom, TW'($urandom));
  endtask
  task automatic push_op(input bit st, input bit sz, input logic [31:0] a, input logic [31:0] d,
                         input logic [TW-1:0] t);
    set_op(st, sz, a, d, t);
    for (int i = 0; i < 60; i++) begin
      step();
      if (pushed) break;
    end
    chk("push_accepted", 32'(pushed), 32'd1);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 400 && (busy || mq.size() > 0); i++) step();
    chk("drained", 32'(busy || mq.size() > 0), 32'd0);
    step();
  endtask
  initial begin
    #1;
    chk("rst_memRead", 32'(memRead), 32'd0);
    chk("rst_fromLSQ", 32'(fromLSQ), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_address", address_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    // store byte then load byte to the same address, both hitting
    miss_pct = 0; rand_data = 0; hit_data = 32'h0000_00AB;
    push_op(1'b1, 1'b1, 32'h1000, 32'hAB, TW'(0));
    push_op(1'b0, 1'b1, 32'h1000, 32'h0, TW'(5));
    drain();
    chk("hit_tag", 32'(res_tag), 32'd5);
    chk("hit_data", res_data, 32'hAB);
    chk("hit_miss", 32'(res_miss), 32'd0);
    chk("hit_latency", 32'(res_n - req_n), 32'd2);
    // load halfword miss
    miss_pct = 100; rand_data = 1;
    push_op(1'b0, 1'b0, 32'h2000, 32'h0, TW'(3));
    drain();
    chk("miss_tag", 32'(res_tag), 32'd3);
    chk("miss_data", res_data, 32'd0);
    chk("miss_flag", 32'(res_miss), 32'd1);
    chk("miss_latency", 32'(res_n - req_n), 32'(P + 2));
    // fill the queue behind a missing load, then stream 16 more ops through wrapped pointers
    for (int i = 0; i < DEPTH; i++) begin
      rand_op();
      in_is_store = 1'b0;
      step();
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    rand_op();
    step();
    chk("ninth_rejected", 32'(pushed), 32'd0);
    in_valid = 1'b0;
    miss_pct = 30;
    for (int k = 0; k < 16; k++)
      push_op(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom, TW'($urandom));
    drain();
    // flush during MISS_WAIT with a simultaneous push
    miss_pct = 100;
    for (int k = 0; k < 3; k++) push_op(1'b0, 1'b0, $urandom, $urandom, TW'(k + 10));
    for (int i = 0; i < 30 && !(busy && n >= req_n + 3); i++) step();
    chk("in_miss_wait", 32'(busy && n >= req_n + 3 && mq.size() == 3), 32'd1);
    rand_op();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_fromLSQ", 32'(fromLSQ), 32'd1);
    repeat (P + 5) step();
    // reset asserted during a REQ cycle
    miss_pct = 0;
    push_op(1'b0, 1'b1, 32'h3000, 32'h0, TW'(7));
    for (int i = 0; i < 10 && !cur_req; i++) step();
    chk("reset_req_seen", 32'(cur_req && memRead), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("reset_memRead", 32'(memRead), 32'd0);
    chk("reset_fromLSQ", 32'(fromLSQ), 32'd1);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) step();
    // interleaved loads and stores issue in push order, two cycles apart
    rand_data = 1;
    reqs.delete();
    for (int k = 0; k < 4; k++) push_op(1'(k % 2), 1'($urandom_range(1)), 32'h4000 + 32'(k * 4),
                                        $urandom, TW'(k + 20));
    drain();
    chk("order_count", 32'(reqs.size()), 32'd4);
    for (int k = 1; k < reqs.size(); k++) chk("order_gap", 32'(reqs[k] - reqs[k-1]), 32'd2);
    // random traffic with occasional flushes
    miss_pct = 25;
    for (int i = 0; i < 400; i++) begin
      rand_op();
      in_valid = 1'($urandom_range(3) != 0);
      flush = 1'($urandom_range(63) == 0);
      step();
    end
    flush = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
